mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum REQ-state cycles awaiting Mem_Ack; legal range 2..255.
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 RST  in  1  reset, asynchronous, active-low.
REQ-004 EX_MEM_Read_Con  in  1  load pending in MEM stage.
REQ-005 EX_MEM_Write_Con  in  1  store pending in MEM stage.
REQ-006 EX_MEM_ALUOut  in  32  byte address of access.
REQ-007 EX_MEM_WData  in  32  store data.
REQ-008 Mem_Ack  in  1  data memory completion strobe, one cycle.
REQ-009 Mem_RData  in  32  read data, valid while Mem_Ack high.
REQ-010 Mem_Req  out  1  memory request, registered.
REQ-011 Mem_We  out  1  1 = write, 0 = read; valid while Mem_Req high.
REQ-012 Mem_Addr  out  32  latched word address (low two bits zero).
REQ-013 Mem_WData  out  32  latched store data.
REQ-014 Pipe_Stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; combinational.
REQ-015 MEM_RData  out  32  load result towards MEM/WB.
REQ-016 MEM_RData_Valid  out  1  MEM_RData holds a completed load.
REQ-017 Misalign_Err  out  1  one-cycle pulse, misaligned access dropped.
REQ-018 Bus_Err  out  1  one-cycle pulse, access timed out.

Function
REQ-019 The FSM SHALL have three states: IDLE, REQ, DONE.
REQ-020 A request SHALL exist in IDLE when Read_Con or Write_Con is 1; when both are 1, the access SHALL be a write.
REQ-021 IDLE with an aligned request (ALUOut[1:0]==0) SHALL move to REQ and latch Mem_Addr, Mem_WData, and Mem_We (1 for write).
REQ-022 IDLE with a misaligned request SHALL move to DONE and pulse Misalign_Err for the DONE cycle; no memory request SHALL be issued.
REQ-023 Mem_Req SHALL be 1 exactly while in REQ; Mem_Addr, Mem_WData, and Mem_We SHALL remain stable throughout REQ.
REQ-024 REQ with Mem_Ack=1 SHALL move to DONE.
REQ-025 On that transition, a read SHALL capture Mem_RData into MEM_RData and set MEM_RData_Valid=1 for the DONE cycle.
REQ-026 A write completion SHALL leave MEM_RData unchanged with MEM_RData_Valid=0.
REQ-027 Wait counter: cleared on entry to REQ and incremented each REQ cycle without ack; 8 bits wide; SHALL NOT wrap.
REQ-028 At count TIMEOUT-1 with no ack, the FSM SHALL move to DONE, pulse Bus_Err, and force MEM_RData=0 with MEM_RData_Valid=0.
REQ-029 Mem_Ack in the same cycle as the timeout condition SHALL win: normal completion, no Bus_Err.
REQ-030 DONE SHALL last exactly one cycle, ignore Read_Con, Write_Con, and Mem_Ack, and return to IDLE.
REQ-031 Pipe_Stall SHALL be 1 in REQ and in IDLE while a request exists, and 0 in DONE and in IDLE without a request.
REQ-032 Minimum aligned-access cost SHALL be three cycles (IDLE, REQ with ack, DONE); a non-memory instruction SHALL incur no stall.
REQ-033 Mem_Ack received outside REQ SHALL be ignored without any output change.

Reset
REQ-034 RST low SHALL immediately force IDLE with Mem_Req=0, Mem_We=0, Mem_Addr=0, Mem_WData=0, MEM_RData=0, MEM_RData_Valid=0, Misalign_Err=0, Bus_Err=0, and wait counter=0.
REQ-035 A reset asserted mid-access SHALL abandon the access; a late Mem_Ack after release SHALL be ignored per REQ-033.
REQ-036 Pipe_Stall SHALL be 0 during reset.

Verification
REQ-037 Read, addr 0x100, ack on 3rd REQ cycle with data 0xDEADBEEF -> Mem_Req high 3 cycles, Mem_We=0, Pipe_Stall high 4 cycles, then MEM_RData=0xDEADBEEF with Valid=1 for 1 cycle.
REQ-038 Write, addr 0x204, data 0x12345678, immediate ack -> Mem_We=1, Mem_Addr=0x204, Mem_WData=0x12345678; Valid stays 0; stall 2 cycles.
REQ-039 Read, addr 0x102 -> Mem_Req never high, Misalign_Err pulse 1 cycle, stall 1 cycle.
REQ-040 TIMEOUT=4, read, no ack -> Mem_Req high 4 cycles, Bus_Err pulse, MEM_RData=0, return to IDLE; second case with ack on 4th cycle -> normal completion, no Bus_Err.
REQ-041 Read and write both asserted on 0x300 -> write issued; RST dropped during REQ -> Mem_Req low the same cycle; ack after release produces no output change.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the MEM-stage access controller (master) and the data memory (slave).
interface mem_access_ctrl_if;
    logic        Mem_Req;
    logic        Mem_We;
    logic [31:0] Mem_Addr;
    logic [31:0] Mem_WData;
    logic        Mem_Ack;
    logic [31:0] Mem_RData;

    modport master (
        output Mem_Req, Mem_We, Mem_Addr, Mem_WData,
        input  Mem_Ack, Mem_RData
    );

    modport slave (
        input  Mem_Req, Mem_We, Mem_Addr, Mem_WData,
        output Mem_Ack, Mem_RData
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: IDLE -> REQ (until Mem_Ack or TIMEOUT) -> DONE, min 3 cycles.
// Backpressure: Pipe_Stall freezes the pipeline while a request waits in IDLE or is outstanding in REQ.
module mem_access_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EX_MEM_Read_Con,
    input  logic              EX_MEM_Write_Con,
    input  logic [31:0]       EX_MEM_ALUOut,
    input  logic [31:0]       EX_MEM_WData,
    mem_access_ctrl_if.master mem,
    output logic              Pipe_Stall,
    output logic [31:0]       MEM_RData,
    output logic              MEM_RData_Valid,
    output logic              Misalign_Err,
    output logic              Bus_Err
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t      state;
    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [7:0]  wait_cnt;
    logic        req_exist;

    assign req_exist = EX_MEM_Read_Con | EX_MEM_Write_Con;

    // Gated by RST so the pipeline is not held while the controller is in reset.
    assign Pipe_Stall = RST & ((state == REQ) | ((state == IDLE) & req_exist));

    assign mem.Mem_Req   = req_q;
    assign mem.Mem_We    = we_q;
    assign mem.Mem_Addr  = addr_q;
    assign mem.Mem_WData = wdata_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state           <= IDLE;
            req_q           <= 1'b0;
            we_q            <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            wait_cnt        <= '0;
            MEM_RData       <= '0;
            MEM_RData_Valid <= 1'b0;
            Misalign_Err    <= 1'b0;
            Bus_Err         <= 1'b0;
        end else begin
            MEM_RData_Valid <= 1'b0;
            Misalign_Err    <= 1'b0;
            Bus_Err         <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_exist) begin
                        if (EX_MEM_ALUOut[1:0] == 2'b00) begin
                            state    <= REQ;
                            req_q    <= 1'b1;
                            we_q     <= EX_MEM_Write_Con;
                            addr_q   <= {EX_MEM_ALUOut[31:2], 2'b00};
                            wdata_q  <= EX_MEM_WData;
                            wait_cnt <= '0;
                        end else begin
                            state        <= DONE;
                            Misalign_Err <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    // Ack is tested first so a same-cycle ack beats the timeout.
                    if (mem.Mem_Ack) begin
                        state <= DONE;
                        req_q <= 1'b0;
                        if (!we_q) begin
                            MEM_RData       <= mem.Mem_RData;
                            MEM_RData_Valid <= 1'b1;
                        end
                    end else if (wait_cnt == LAST_WAIT) begin
                        state     <= DONE;
                        req_q     <= 1'b0;
                        Bus_Err   <= 1'b1;
                        MEM_RData <= '0;
                    end else if (wait_cnt != 8'hFF) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed cases plus randomized transactions vs. a transaction-level model.
module tb_mem_access_ctrl;
    localparam int TO = 4;

    logic        CLK;
    logic        RST;
    logic        EX_MEM_Read_Con;
    logic        EX_MEM_Write_Con;
    logic [31:0] EX_MEM_ALUOut;
    logic [31:0] EX_MEM_WData;
    logic        Pipe_Stall;
    logic [31:0] MEM_RData;
    logic        MEM_RData_Valid;
    logic        Misalign_Err;
    logic        Bus_Err;

    mem_access_ctrl_if mem ();

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .CLK             (CLK),
        .RST             (RST),
        .EX_MEM_Read_Con (EX_MEM_Read_Con),
        .EX_MEM_Write_Con(EX_MEM_Write_Con),
        .EX_MEM_ALUOut   (EX_MEM_ALUOut),
        .EX_MEM_WData    (EX_MEM_WData),
        .mem             (mem),
        .Pipe_Stall      (Pipe_Stall),
        .MEM_RData       (MEM_RData),
        .MEM_RData_Valid (MEM_RData_Valid),
        .Misalign_Err    (Misalign_Err),
        .Bus_Err         (Bus_Err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_rdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One full access from the IDLE cycle through DONE and two following IDLE cycles.
    // ack_at: REQ cycle (1-based) in which the memory acks; beyond TO means never.
    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int ack_at, input logic [31:0] rdata);
        int   req_cnt;
        int   stall_cnt;
        int   exp_req;
        logic aligned;
        logic timeout;
        logic exp_vld;

        aligned = (addr[1:0] == 2'b00);
        timeout = aligned && (ack_at > TO);
        exp_req = !aligned ? 0 : (timeout ? TO : ack_at);
        exp_vld = aligned && !timeout && !wr;

        EX_MEM_Read_Con  = rd;
        EX_MEM_Write_Con = wr;
        EX_MEM_ALUOut    = addr;
        EX_MEM_WData     = wdata;
        mem.Mem_Ack      = 1'($urandom_range(0, 1));
        mem.Mem_RData    = $urandom;
        #1;
        stall_cnt = int'(Pipe_Stall);
        req_cnt   = 0;
        chk("idle_mem_req", {31'd0, mem.Mem_Req}, 32'd0);

        @(posedge CLK); #1;
        while (mem.Mem_Req && req_cnt < 40) begin
            req_cnt++;
            stall_cnt += int'(Pipe_Stall);
            chk("mem_we", {31'd0, mem.Mem_We}, {31'd0, wr});
            chk("mem_addr", mem.Mem_Addr, addr);
            chk("mem_wdata", mem.Mem_WData, wdata);
            EX_MEM_ALUOut = $urandom;
            EX_MEM_WData  = $urandom;
            mem.Mem_Ack   = (req_cnt == ack_at);
            mem.Mem_RData = (req_cnt == ack_at) ? rdata : $urandom;
            @(posedge CLK); #1;
        end
        chk("req_loop_end", {31'd0, mem.Mem_Req}, 32'd0);

        // DONE: inputs and ack are randomized and must be ignored.
        EX_MEM_Read_Con  = 1'($urandom_range(0, 1));
        EX_MEM_Write_Con = 1'($urandom_range(0, 1));
        EX_MEM_ALUOut    = $urandom;
        mem.Mem_Ack      = 1'($urandom_range(0, 1));
        mem.Mem_RData    = $urandom;
        #1;
        stall_cnt += int'(Pipe_Stall);

        if (exp_vld)      exp_rdata = rdata;
        else if (timeout) exp_rdata = 32'd0;

        chk("req_cycles", req_cnt, exp_req);
        chk("stall_cycles", stall_cnt, exp_req + 1);
        chk("done_rdata", MEM_RData, exp_rdata);
        chk("done_valid", {31'd0, MEM_RData_Valid}, {31'd0, exp_vld});
        chk("done_misalign", {31'd0, Misalign_Err}, {31'd0, !aligned});
        chk("done_bus_err", {31'd0, Bus_Err}, {31'd0, timeout});

        @(posedge CLK); #1;
        EX_MEM_Read_Con  = 1'b0;
        EX_MEM_Write_Con = 1'b0;
        mem.Mem_Ack      = 1'b1;
        mem.Mem_RData    = $urandom;
        #1;
        chk("idle_stall", {31'd0, Pipe_Stall}, 32'd0);
        chk("idle_valid", {31'd0, MEM_RData_Valid}, 32'd0);
        chk("idle_pulses", {30'd0, Misalign_Err, Bus_Err}, 32'd0);

        @(posedge CLK); #1;
        mem.Mem_Ack = 1'b0;
        chk("stray_ack_req", {31'd0, mem.Mem_Req}, 32'd0);
        chk("stray_ack_rdata", MEM_RData, exp_rdata);
        chk("stray_ack_valid", {31'd0, MEM_RData_Valid}, 32'd0);
    endtask

    initial begin
        logic        rd;
        logic        wr;
        logic [31:0] addr;

        RST              = 1'b0;
        EX_MEM_Read_Con  = 1'b1;
        EX_MEM_Write_Con = 1'b0;
        EX_MEM_ALUOut    = 32'h100;
        EX_MEM_WData     = 32'h0;
        mem.Mem_Ack      = 1'b0;
        mem.Mem_RData    = 32'h0;
        exp_rdata        = 32'd0;
        #12;
        chk("rst_stall", {31'd0, Pipe_Stall}, 32'd0);
        chk("rst_req_we", {30'd0, mem.Mem_Req, mem.Mem_We}, 32'd0);
        chk("rst_addr", mem.Mem_Addr, 32'd0);
        chk("rst_wdata", mem.Mem_WData, 32'd0);
        chk("rst_rdata", MEM_RData, 32'd0);
        chk("rst_flags", {29'd0, MEM_RData_Valid, Misalign_Err, Bus_Err}, 32'd0);
        EX_MEM_Read_Con = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK); #1;
        chk("idle_no_req_stall", {31'd0, Pipe_Stall}, 32'd0);

        run_txn(1'b1, 1'b0, 32'h100, 32'h0,        3,  32'hDEADBEEF);
        run_txn(1'b0, 1'b1, 32'h204, 32'h12345678, 1,  32'h0);
        run_txn(1'b1, 1'b0, 32'h102, 32'h0,        1,  32'h0);
        run_txn(1'b1, 1'b0, 32'h180, 32'h0,        99, 32'h0);
        run_txn(1'b1, 1'b0, 32'h184, 32'h0,        TO, 32'hA5A55A5A);
        run_txn(1'b1, 1'b1, 32'h300, 32'hFEEDF00D, 2,  32'h11111111);

        // Reset in the middle of REQ abandons the access; a late ack does nothing.
        EX_MEM_Read_Con = 1'b1;
        EX_MEM_ALUOut   = 32'h400;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("mid_req_active", {31'd0, mem.Mem_Req}, 32'd1);
        RST = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, mem.Mem_Req}, 32'd0);
        chk("mid_rst_stall", {31'd0, Pipe_Stall}, 32'd0);
        chk("mid_rst_addr", mem.Mem_Addr, 32'd0);
        EX_MEM_Read_Con = 1'b0;
        exp_rdata       = 32'd0;
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK); #1;
        mem.Mem_Ack   = 1'b1;
        mem.Mem_RData = 32'hCAFEF00D;
        @(posedge CLK); #1;
        mem.Mem_Ack = 1'b0;
        chk("late_ack_req", {31'd0, mem.Mem_Req}, 32'd0);
        chk("late_ack_rdata", MEM_RData, 32'd0);
        chk("late_ack_flags", {29'd0, MEM_RData_Valid, Misalign_Err, Bus_Err}, 32'd0);

        for (int i = 0; i < 60; i++) begin
            rd   = 1'($urandom_range(0, 1));
            wr   = rd ? 1'($urandom_range(0, 1)) : 1'b1;
            addr = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            run_txn(rd, wr, addr, $urandom, int'($urandom_range(1, TO + 2)), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
